// File: rtl/sensor_trigger_sequencer_if.sv
// Signal bundle between the trigger sequencer and its controller/sensor side.
// The slave modport is the sequencer; the master modport drives triggers, config and raw done levels.
`timescale 1ns/1ps
interface sensor_trigger_sequencer_if #(
  parameter int N_SENSORS = 10,
  parameter int CNT_W     = 16
);
  logic                         trigger;
  logic [N_SENSORS-1:0]         en_bits;
  logic [N_SENSORS*CNT_W-1:0]   start_delay;
  logic [CNT_W-1:0]             timeout_cycles;
  logic                         clear_flags;
  logic [N_SENSORS-1:0]         done_raw;
  logic [N_SENSORS-1:0]         sensor_start;
  logic [N_SENSORS-1:0]         done_latched;
  logic                         busy;
  logic                         seq_done;
  logic [N_SENSORS-1:0]         timeout_flags;
  logic                         overrun;

  modport slave (
    input  trigger, en_bits, start_delay, timeout_cycles, clear_flags, done_raw,
    output sensor_start, done_latched, busy, seq_done, timeout_flags, overrun
  );

  modport master (
    output trigger, en_bits, start_delay, timeout_cycles, clear_flags, done_raw,
    input  sensor_start, done_latched, busy, seq_done, timeout_flags, overrun
  );
endinterface

// File: rtl/sensor_trigger_sequencer.sv
// Per-trigger sensor start sequencer: delayed start pulses, done-edge collection and a watchdog
// that forces stuck sensors done so the timing manager never stalls.
`timescale 1ns/1ps
module sensor_trigger_sequencer #(
  parameter int N_SENSORS = 10,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  sensor_trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     counter, counter_nxt;
  logic [N_SENSORS-1:0] active, active_nxt;
  logic [N_SENSORS-1:0] started, started_nxt;
  logic [N_SENSORS-1:0] done_q;
  logic [N_SENSORS-1:0] start_q, start_nxt;
  logic [N_SENSORS-1:0] done_l, done_nxt;
  logic [N_SENSORS-1:0] flags_q, flags_nxt;
  logic                 busy_q, busy_nxt;
  logic                 seq_q, seq_nxt;
  logic                 ovr_q, ovr_nxt;

  logic [N_SENSORS-1:0] rise, done_set, zero_dly, due;
  logic                 wdog;

  // A channel is due when the counter value seen on the next edge equals its delay.
  always_comb begin
    zero_dly = '0;
    due      = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      zero_dly[i] = (bus.start_delay[i*CNT_W +: CNT_W] == '0);
      due[i]      = active[i] & ~started[i] &
                    (({1'b0, counter} + ONE_EXT) == {1'b0, bus.start_delay[i*CNT_W +: CNT_W]});
    end
  end

  assign rise     = bus.done_raw & ~done_q;
  assign done_set = rise & active & started;
  assign wdog     = (state == RUN) && (bus.timeout_cycles != '0) && (counter == bus.timeout_cycles);

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    active_nxt  = active;
    started_nxt = started;
    start_nxt   = '0;
    done_nxt    = done_l;
    flags_nxt   = flags_q & ~{N_SENSORS{bus.clear_flags}};
    ovr_nxt     = ovr_q & ~bus.clear_flags;
    seq_nxt     = (state == FINISH);
    busy_nxt    = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.trigger) begin
          active_nxt  = bus.en_bits;
          done_nxt    = '0;
          counter_nxt = '0;
          started_nxt = bus.en_bits & zero_dly;
          start_nxt   = bus.en_bits & zero_dly;
          state_nxt   = (bus.en_bits == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (bus.trigger) ovr_nxt = 1'b1;
        if (counter != '1) counter_nxt = counter + CNT_W'(1);
        done_nxt = done_l | done_set;
        // A same-cycle done edge is already in done_nxt, so it is not flagged.
        if (wdog) begin
          flags_nxt = flags_nxt | (active & ~done_nxt);
          done_nxt  = done_nxt | active;
          state_nxt = FINISH;
        end else begin
          start_nxt   = due;
          started_nxt = started | due;
          if (&(done_nxt | ~active)) state_nxt = FINISH;
        end
      end
      FINISH: begin
        if (bus.trigger) ovr_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      active  <= '0;
      started <= '0;
      done_q  <= '0;
      start_q <= '0;
      done_l  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      seq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      active  <= active_nxt;
      started <= started_nxt;
      done_q  <= bus.done_raw;
      start_q <= start_nxt;
      done_l  <= done_nxt;
      flags_q <= flags_nxt;
      busy_q  <= busy_nxt;
      seq_q   <= seq_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  assign bus.sensor_start  = start_q;
  assign bus.done_latched  = done_l;
  assign bus.busy          = busy_q;
  assign bus.seq_done      = seq_q;
  assign bus.timeout_flags = flags_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_sensor_trigger_sequencer.sv
// Bench for sensor_trigger_sequencer: scenario vectors, hand-written corner sequences and
// random traffic, all checked cycle by cycle against a time-based acquisition model.
`timescale 1ns/1ps
module tb_sensor_trigger_sequencer;

  localparam int NS = 10;
  localparam int CW = 16;

  logic clk;
  logic rst;

  sensor_trigger_sequencer_if #(.N_SENSORS(NS), .CNT_W(CW)) bus ();

  sensor_trigger_sequencer #(.N_SENSORS(NS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  int cur_dly[NS];
  int cur_to;

  // Model state: times are clock-edge indices; outputs are those visible after edge n.
  int          n;
  bit          m_acq;
  bit          f_known;
  int          t0;
  int          f;
  logic [9:0]  m_act, m_acc, m_start, m_flags, m_prev;
  bit          m_ovr, m_busy, m_seq;
  int          m_dly[NS];
  int          m_to;

  typedef struct {
    logic [9:0] en;
    int ca; int cb; int da; int db;
    int pre_a; int ra; int rb; int to;
    int exp_sa; int exp_sb; int exp_seq; int exp_nst;
    logic [9:0] exp_done;
    logic [9:0] exp_flags;
  } vec_t;

  vec_t vecs[7];

  function automatic void modelReset();
    m_acq = 0; f_known = 0; t0 = -100; f = -100;
    m_act = '0; m_acc = '0; m_start = '0; m_flags = '0; m_prev = '0;
    m_ovr = 0; m_busy = 0; m_seq = 0; m_to = 0;
    for (int i = 0; i < NS; i++) m_dly[i] = 0;
  endfunction

  function automatic bit modelCanAccept();
    return !m_acq && !(f_known && (n + 1) == (f + 1));
  endfunction

  function automatic void modelStep(input logic trig, input logic [9:0] en,
                                    input logic clr, input logic [9:0] raw);
    logic [9:0] rise, flag_ev;
    bit         ovr_ev, wd;
    n++;
    rise    = raw & ~m_prev;
    m_prev  = raw;
    m_start = '0;
    flag_ev = '0;
    ovr_ev  = 0;
    if (m_acq) begin
      for (int i = 0; i < NS; i++)
        if (m_act[i] && !m_acc[i] && rise[i] && n >= t0 + m_dly[i] + 1) m_acc[i] = 1'b1;
      wd = (m_to != 0) && ((n - t0 - 1) == m_to);
      if (wd) begin
        for (int i = 0; i < NS; i++)
          if (m_act[i] && !m_acc[i]) begin m_acc[i] = 1'b1; flag_ev[i] = 1'b1; end
      end else begin
        for (int i = 0; i < NS; i++)
          if (m_act[i] && n == t0 + m_dly[i]) m_start[i] = 1'b1;
      end
      if (wd || ((m_acc | ~m_act) == 10'h3FF)) begin
        f = n; f_known = 1; m_acq = 0;
      end
      if (trig) ovr_ev = 1;
    end else if (f_known && n == f + 1) begin
      if (trig) ovr_ev = 1;
    end else if (trig) begin
      t0 = n; m_act = en; m_acc = '0; m_to = cur_to;
      for (int i = 0; i < NS; i++) begin
        m_dly[i] = cur_dly[i];
        if (en[i] && cur_dly[i] == 0) m_start[i] = 1'b1;
      end
      if (en == '0) begin f = n; f_known = 1; end
      else begin m_acq = 1; f_known = 0; end
    end
    m_flags = (m_flags & ~{10{clr}}) | flag_ev;
    m_ovr   = (m_ovr & ~clr) | ovr_ev;
    m_busy  = m_acq ? (n >= t0 + 1) : (f_known && n >= t0 + 1 && n <= f + 1);
    m_seq   = f_known && (n == f + 1);
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  task automatic checkOutput();
    check_val("start", 32'(bus.sensor_start),  32'(m_start));
    check_val("done",  32'(bus.done_latched),  32'(m_act & m_acc));
    check_val("busy",  32'(bus.busy),          32'(m_busy));
    check_val("seq",   32'(bus.seq_done),      32'(m_seq));
    check_val("flags", 32'(bus.timeout_flags), 32'(m_flags));
    check_val("ovr",   32'(bus.overrun),       32'(m_ovr));
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < NS; i++) bus.start_delay[i*CW +: CW] = CW'(cur_dly[i]);
    bus.timeout_cycles = CW'(cur_to);
  endtask

  task automatic applyStimulus(input logic trig, input logic [9:0] en,
                               input logic clr, input logic [9:0] raw);
    bus.trigger     = trig;
    bus.en_bits     = en;
    bus.clear_flags = clr;
    bus.done_raw    = raw;
    @(posedge clk);
    modelStep(trig, en, clr, raw);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_start"}, 32'(bus.sensor_start),  32'h0);
    check_val({tag, "_done"},  32'(bus.done_latched),  32'h0);
    check_val({tag, "_busy"},  32'(bus.busy),          32'h0);
    check_val({tag, "_seq"},   32'(bus.seq_done),      32'h0);
    check_val({tag, "_flags"}, 32'(bus.timeout_flags), 32'h0);
    check_val({tag, "_ovr"},   32'(bus.overrun),       32'h0);
  endtask

  task automatic prep_idle();
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, '0);
    check_val("flags_cleared", 32'(bus.timeout_flags), 32'h0);
    check_val("ovr_cleared",   32'(bus.overrun),       32'h0);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int obs_sa, obs_sb, obs_seq, obs_low, nst;
    bit seen_busy;
    logic [9:0] raw;
    prep_idle();
    for (int i = 0; i < NS; i++) cur_dly[i] = 0;
    cur_dly[v.ca] = v.da;
    cur_dly[v.cb] = v.db;
    cur_to = v.to;
    drive_cfg();
    obs_sa = -1; obs_sb = -1; obs_seq = -1; obs_low = -1; nst = 0; seen_busy = 0;
    for (int k = 0; k <= v.exp_seq + 3; k++) begin
      raw = '0;
      if (v.ra >= 0 && k >= v.ra) raw[v.ca] = 1'b1;
      if (v.rb >= 0 && k >= v.rb) raw[v.cb] = 1'b1;
      if (v.pre_a >= 0 && (k == v.pre_a || k == v.pre_a + 1)) raw[v.ca] = 1'b1;
      applyStimulus(k == 0, v.en, 1'b0, raw);
      if (bus.sensor_start[v.ca] && obs_sa < 0) obs_sa = k;
      if (bus.sensor_start[v.cb] && obs_sb < 0) obs_sb = k;
      nst += $countones(bus.sensor_start);
      if (bus.seq_done && obs_seq < 0) obs_seq = k;
      if (bus.busy) seen_busy = 1;
      else if (seen_busy && obs_low < 0) obs_low = k;
    end
    check_val($sformatf("vec%0d_start_a", idx),   32'(obs_sa),  32'(v.exp_sa));
    check_val($sformatf("vec%0d_start_b", idx),   32'(obs_sb),  32'(v.exp_sb));
    check_val($sformatf("vec%0d_seq_time", idx),  32'(obs_seq), 32'(v.exp_seq));
    check_val($sformatf("vec%0d_busy_low", idx),  32'(obs_low), 32'(v.exp_seq + 1));
    check_val($sformatf("vec%0d_nstarts", idx),   32'(nst),     32'(v.exp_nst));
    check_val($sformatf("vec%0d_done", idx),      32'(bus.done_latched),  32'(v.exp_done));
    check_val($sformatf("vec%0d_flags", idx),     32'(bus.timeout_flags), 32'(v.exp_flags));
  endtask

  task automatic seq_overrun();
    int nst, obs_seq;
    prep_idle();
    for (int i = 0; i < NS; i++) cur_dly[i] = 0;
    cur_dly[0] = 10;
    cur_to = 0;
    drive_cfg();
    nst = 0; obs_seq = -1;
    for (int k = 0; k <= 20; k++) begin
      applyStimulus((k == 0 || k == 3 || k == 5), (k == 0) ? 10'h001 : 10'h3FF,
                    (k == 5), (k >= 15) ? 10'h001 : 10'h000);
      nst += $countones(bus.sensor_start);
      if (bus.seq_done && obs_seq < 0) obs_seq = k;
      if (k == 3) check_val("ovr_set", 32'(bus.overrun), 32'h1);
      if (k == 5) check_val("ovr_set_wins", 32'(bus.overrun), 32'h1);
    end
    check_val("ovr_nstarts", 32'(nst), 32'd1);
    check_val("ovr_seq_time", 32'(obs_seq), 32'd16);
    check_val("ovr_mask_kept", 32'(bus.done_latched), 32'h001);
    applyStimulus(1'b0, '0, 1'b1, '0);
    check_val("ovr_clear", 32'(bus.overrun), 32'h0);
  endtask

  task automatic seq_reset_mid();
    int nst;
    prep_idle();
    for (int i = 0; i < NS; i++) cur_dly[i] = 0;
    cur_dly[0] = 20;
    cur_to = 0;
    drive_cfg();
    for (int k = 0; k < 5; k++) applyStimulus(k == 0, 10'h001, 1'b0, '0);
    check_val("pre_reset_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    nst = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b0, 10'h001, 1'b0, '0);
      nst += $countones(bus.sensor_start);
    end
    check_val("reset_no_start", 32'(nst), 32'd0);
  endtask

  initial begin
    logic [9:0] raw, en;
    logic       trig, clr;

    vecs[0] = '{10'h003, 0, 1, 0,  5, -1, 10, 15,  0,  0,  5, 16,  2, 10'h003, 10'h000};
    vecs[1] = '{10'h004, 2, 3, 0,  0, -1, -1, -1, 50,  0, -1, 52,  1, 10'h004, 10'h004};
    vecs[2] = '{10'h000, 0, 1, 0,  0, -1, -1, -1,  0, -1, -1,  1,  0, 10'h000, 10'h000};
    vecs[3] = '{10'h001, 0, 1, 8,  0,  3, 12, -1,  0,  8, -1, 13,  1, 10'h001, 10'h000};
    vecs[4] = '{10'h003, 0, 1, 3, 20, -1,  6, -1, 10,  3, -1, 12,  1, 10'h003, 10'h002};
    vecs[5] = '{10'h001, 0, 1, 0,  0, -1,  8, -1,  7,  0, -1,  9,  1, 10'h001, 10'h000};
    vecs[6] = '{10'h3FF, 9, 5, 2,  4, -1,  5,  9, 20,  2,  4, 22, 10, 10'h3FF, 10'h1DF};

    n = 0;
    modelReset();
    for (int i = 0; i < NS; i++) cur_dly[i] = 0;
    cur_to = 0;
    bus.trigger = 1'b0; bus.en_bits = '0; bus.clear_flags = 1'b0; bus.done_raw = '0;
    drive_cfg();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] scenario vectors");
    for (int v = 0; v < 7; v++) run_vector(v, vecs[v]);

    $display("[TB] overrun sequence");
    seq_overrun();

    $display("[TB] reset during run");
    seq_reset_mid();

    $display("[TB] random traffic");
    raw = '0;
    for (int c = 0; c < 3000; c++) begin
      trig = ($urandom_range(0, 11) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      en   = 10'($urandom);
      if ($urandom_range(0, 7) == 0) en = '0;
      if (trig && modelCanAccept()) begin
        for (int i = 0; i < NS; i++) cur_dly[i] = $urandom_range(0, 12);
        cur_to = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 30);
        drive_cfg();
      end
      raw = raw ^ (10'($urandom) & 10'($urandom));
      applyStimulus(trig, en, clr, raw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sensor_trigger_sequencer.md
Name: sensor_trigger_sequencer

Overview:
- Sits between the timing manager's trigger output and the sensor interface blocks (ADC, encoder, AMDS x4, eddy x4).
- On each trigger, issues per-sensor start pulses to the enabled sensors, with a programmable per-sensor delay after the trigger.
- Collects each sensor's raw completion edge into a level done vector, which feeds the timing manager's done inputs.
- Enforces a watchdog timeout so a dead sensor cannot stall the scheduler.

Parameters:
- N_SENSORS, 10, number of sensor channels; bit order matches the driver's sensor_e enumeration (0=ADC, 1=encoder, 2-5=AMDS 0-3, 6-9=eddy 0-3).
- CNT_W, 16, width of the cycle counter, the delays and the timeout.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- trigger  in  1  single-cycle acquisition trigger from the timing manager.
- en_bits  in  N_SENSORS  sensor enable mask; sampled only on an accepted trigger.
- start_delay  in  N_SENSORS*CNT_W  per-sensor delay in cycles; channel i uses bits [i*CNT_W +: CNT_W].
- timeout_cycles  in  CNT_W  watchdog limit in cycles; 0 disables the watchdog.
- clear_flags  in  1  single-cycle pulse that clears the sticky flags.
- done_raw  in  N_SENSORS  raw done levels from the sensors; only rising edges are used.
- sensor_start  out  N_SENSORS  one-cycle start pulse per sensor.
- done_latched  out  N_SENSORS  level done per sensor, to the timing manager.
- busy  out  1  high while in RUN.
- seq_done  out  1  one-cycle pulse when an acquisition finishes (normally or by timeout).
- timeout_flags  out  N_SENSORS  sticky; the sensor was forced done by the watchdog.
- overrun  out  1  sticky; a trigger arrived while busy.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0, active mask 0, started mask 0.
- FSM states:
  - IDLE: on trigger, latch active=en_bits, clear done_latched and the started mask, set counter=0, go to RUN.
  - IDLE with an empty mask: a trigger with en_bits==0 goes to FINISH directly; no starts are issued.
  - RUN: counter increments each cycle and saturates at 2^CNT_W-1 (no wrap).
  - RUN: go to FINISH when (done_latched | ~active) is all ones, or when the watchdog fires.
  - FINISH: pulse seq_done for one cycle, go to IDLE. done_latched holds its value until the next accepted trigger.
- Start timing:
  - sensor_start[i] is registered and high for exactly one cycle.
  - For an active channel it asserts in cycle T+1+start_delay[i], where T is the cycle trigger is sampled high. Delay 0 gives a pulse at T+1.
  - Each channel starts at most once per acquisition; the started mask records it.
- Done capture:
  - done_raw is registered once for edge detection.
  - A rising edge on an active channel whose start has been issued sets done_latched[i] on the next clock.
  - Edges before start, or on inactive channels, are ignored.
- Watchdog:
  - Fires when timeout_cycles!=0 and counter==timeout_cycles while in RUN.
  - Every active channel not yet done gets done_latched[i]=1 and timeout_flags[i]=1; go to FINISH.
  - Active channels not yet started when it fires are also forced done and flagged.
  - If a done edge and the watchdog occur in the same cycle on a channel, the done wins and the channel is not flagged.
- Flags:
  - A trigger while in RUN or FINISH is ignored and sets overrun.
  - clear_flags zeroes timeout_flags and overrun.
  - If clear_flags coincides with a new flag event, the set wins.
- Configuration: changing en_bits or start_delay mid-acquisition has no effect on en_bits (already latched); start_delay is read live, so software must change it only while busy=0.
- Reset mid-operation: returns immediately to reset values; no further start pulses.

Test Plan:
- en_bits=0x003, delays ADC=0 and ENC=5, trigger at cycle 10 -> sensor_start[0] at 11, sensor_start[1] at 16; done_raw[0] rises at 20 and done_raw[1] at 25 -> done_latched bits set at 21 and 26, seq_done at 27, busy low at 28.
- en_bits=0x004, timeout_cycles=50, done_raw never rises -> done_latched[2]=1 and timeout_flags=0x004 after 50 counts, one seq_done pulse; clear_flags -> timeout_flags=0.
- A second trigger while busy -> overrun=1, the active mask is unchanged, no extra start pulses.
- en_bits=0x000 trigger -> no starts, seq_done pulse 2 cycles after the trigger, done_latched=0.
- done_raw[0] pulses before its start (delay=8) -> ignored; the later post-start edge latches the bit.
- rst asserted during RUN with a start pending -> all outputs 0 immediately, the pending start is never issued.
